clk_seq_ctrl: RTL

CLK_SEQ_CTRL -- requirements
Module: clk_seq_ctrl

---
 rtl/clk_seq_ctrl.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/clk_seq_ctrl.sv
// clk_seq_ctrl: start-up / shutdown sequencer for an external clock generator
// running from clk_8f. It brings the generator up through a held-reset phase
// and a warm-up phase, then flags derived clocks valid. It tracks the clk_8f
// position within each clk_f period and drains the current clk_f period on
// a graceful stop.
//
// Optional feature: define CLK_SEQ_STATS_EN to add the per_cnt clk_f period
// counter.
//
// Ports
//   clk_8f   in   sole clock, rising edge
//   rst      in   asynchronous reset, active low
//   start    in   level request to bring the generator up
//   stop     in   level request for graceful shutdown (beats start)
//   gen_rst  out  active-high reset to the generator
//   gen_enb  out  generator enable
//   ready    out  derived clocks valid (RUN only)
//   busy     out  sequencer not idle
//   phase    out  clk_8f position within the clk_f period
//   stb_2f   out  strobe on the last clk_8f cycle of each clk_2f period
//   stb_f    out  strobe on the last clk_8f cycle of each clk_f period
//   per_cnt  out  clk_f periods seen in RUN/DRAIN (CLK_SEQ_STATS_EN only)
module clk_seq_ctrl #(
  parameter int unsigned RST_CYC    = 2,  // 1..15
  parameter int unsigned WARMUP_CYC = 8   // 8, 16, 24 or 32
) (
  input  logic        clk_8f,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  output logic        gen_rst,
  output logic        gen_enb,
  output logic        ready,
  output logic        busy,
  output logic [2:0]  phase,
  output logic        stb_2f,
  output logic        stb_f
`ifdef CLK_SEQ_STATS_EN
  ,
  output logic [15:0] per_cnt
`endif
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned WCNT_W = 5;
  localparam int unsigned PH_W   = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RSTGEN = 3'd1,
    WARMUP = 3'd2,
    RUN    = 3'd3,
    DRAIN  = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
  logic [PH_W-1:0]     phase_q, phase_d;
  logic                req_q, req_d;
  logic                gen_rst_q, gen_rst_d;
  logic                gen_enb_q, gen_enb_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                stb_2f_q, stb_2f_d;
  logic                stb_f_q, stb_f_d;

  // Next-state, counters and output decode; outputs are decoded from the
  // next state so each registered output matches the state it is shown in.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wcnt_d  = wcnt_q;
    phase_d = phase_q;
    req_d   = 1'b0;

    case (state_q)
      // start is captured into req_q first; the sequence launches on the
      // following edge unless stop is raised meanwhile.
      IDLE: begin
        phase_d = '0;
        if (stop) begin
          req_d = 1'b0;
        end else if (req_q) begin
          state_d = RSTGEN;
          cnt_d   = '0;
        end else begin
          req_d = start;
        end
      end
      RSTGEN: begin
        if (stop) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(RST_CYC - 1)) begin
          state_d = WARMUP;
          phase_d = '0;
          wcnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      // WARMUP_CYC is a multiple of 8, so phase wraps to 0 on RUN entry.
      WARMUP: begin
        if (stop) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
          wcnt_d  = wcnt_q + WCNT_W'(1);
          if (wcnt_q == WCNT_W'(WARMUP_CYC - 1)) begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        phase_d = phase_q + PH_W'(1);
        if (stop) begin
          state_d = DRAIN;
        end
      end
      // Finish the current clk_f period; neither start nor stop matters here.
      DRAIN: begin
        if (phase_q == PH_W'(7)) begin
          state_d = IDLE;
          phase_d = '0;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase

    gen_rst_d = (state_d == IDLE) || (state_d == RSTGEN);
    gen_enb_d = (state_d == WARMUP) || (state_d == RUN) || (state_d == DRAIN);
    ready_d   = (state_d == RUN);
    busy_d    = (state_d != IDLE);
    stb_2f_d  = ((state_d == RUN) || (state_d == DRAIN)) && (phase_d[1:0] == 2'd3);
    stb_f_d   = ((state_d == RUN) || (state_d == DRAIN)) && (phase_d == PH_W'(7));
  end

  // State, counter and output registers.
  always_ff @(posedge clk_8f or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      wcnt_q    <= '0;
      phase_q   <= '0;
      req_q     <= 1'b0;
      gen_rst_q <= 1'b1;
      gen_enb_q <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      stb_2f_q  <= 1'b0;
      stb_f_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wcnt_q    <= wcnt_d;
      phase_q   <= phase_d;
      req_q     <= req_d;
      gen_rst_q <= gen_rst_d;
      gen_enb_q <= gen_enb_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      stb_2f_q  <= stb_2f_d;
      stb_f_q   <= stb_f_d;
    end
  end

  assign gen_rst = gen_rst_q;
  assign gen_enb = gen_enb_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign phase   = phase_q;
  assign stb_2f  = stb_2f_q;
  assign stb_f   = stb_f_q;

`ifdef CLK_SEQ_STATS_EN
  logic [15:0] per_cnt_q, per_cnt_d;

  // Counts clk_f periods in step with stb_f; only rst clears it.
  always_comb begin
    per_cnt_d = per_cnt_q;
    if (stb_f_d) begin
      per_cnt_d = per_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_8f or negedge rst) begin
    if (!rst) begin
      per_cnt_q <= '0;
    end else begin
      per_cnt_q <= per_cnt_d;
    end
  end

  assign per_cnt = per_cnt_q;
`endif

endmodule
